// File: rtl/tff_updown_counter.sv
// Up/down counter built from WIDTH toggle stages with parallel load, a
// combinational terminal-count strobe and a sticky wrap/saturate flag.
module tff_updown_counter #(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_bar,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_tog;
    logic             w_at_lim;

    // Stage i toggles when every lower stage is 1 (up) or 0 (down).
    assign w_tog[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign w_tog[i] = up_dn ? (&r_cnt[i-1:0]) : ~(|r_cnt[i-1:0]);
    end

    assign w_at_lim = up_dn ? (&r_cnt) : ~(|r_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val;
            r_ovf <= 1'b0;
        end else if (en) begin
            if (w_at_lim) begin
                r_ovf <= 1'b1;
            end
            // In saturate mode the toggles are suppressed at the limit.
            if (WRAP || !w_at_lim) begin
                r_cnt <= r_cnt ^ w_tog;
            end
        end
    end

    assign cnt     = r_cnt;
    assign cnt_bar = ~r_cnt;
    assign ovf     = r_ovf;
    assign tc      = en & ~load & w_at_lim;

endmodule
